// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, control encodings
// and the D/E pipeline bundle used by the core stages.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic            regWrite;
    logic [1:0]      resultSrc;
    logic            memWrite;
    logic            jump;
    logic            branch;
    logic [2:0]      aluControl;
    logic            aluSrc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] immExt;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
  } id_ex_t;

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file, x0 hardwired zero,
// write-through so writeback is visible to decode same cycle.
module register_file
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] a1,
  input  logic [REG_ADDR_W-1:0] a2,
  input  logic                  we3,
  input  logic [REG_ADDR_W-1:0] a3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  localparam int N = 2 ** REG_ADDR_W;

  logic [DATA_WIDTH-1:0] regs [N];
  logic                  wrEn;

  assign wrEn = we3 && (a3 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        regs[i] <= '0;
    end else if (wrEn) begin
      regs[a3] <= wd3;
    end
  end

  always_comb begin
    rd1 = regs[a1];
    rd2 = regs[a2];
    if (a1 == '0)
      rd1 = '0;
    else if (wrEn && a3 == a1)
      rd1 = wd3;
    if (a2 == '0)
      rd2 = '0;
    else if (wrEn && a3 == a2)
      rd2 = wd3;
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read,
// immediate extend and the D/E pipeline register.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = REGW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  FlushE,
  output logic [REG_ADDR_W-1:0] Rs1D,
  output logic [REG_ADDR_W-1:0] Rs2D,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [2:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       regWrite;
  logic [1:0] immSrc;
  logic       aluSrc;
  logic       memWrite;
  logic [1:0] resultSrc;
  logic       branch;
  logic [1:0] aluOp;
  logic       jump;
  logic [2:0] aluControl;
  logic [31:0] immExt;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;
  id_ex_t     nextE;
  id_ex_t     regE;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  always_comb begin
    regWrite  = 1'b0;
    immSrc    = IMM_I;
    aluSrc    = 1'b0;
    memWrite  = 1'b0;
    resultSrc = RES_ALU;
    branch    = 1'b0;
    aluOp     = ALUOP_ADD;
    jump      = 1'b0;
    unique case (1'b1)
      opcode == OP_LW: begin
        regWrite  = 1'b1;
        aluSrc    = 1'b1;
        resultSrc = RES_MEM;
      end
      opcode == OP_SW: begin
        immSrc   = IMM_S;
        aluSrc   = 1'b1;
        memWrite = 1'b1;
      end
      opcode == OP_R: begin
        regWrite = 1'b1;
        aluOp    = ALUOP_FN;
      end
      opcode == OP_B: begin
        immSrc = IMM_B;
        branch = 1'b1;
        aluOp  = ALUOP_SUB;
      end
      opcode == OP_I: begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        aluOp    = ALUOP_FN;
      end
      opcode == OP_JAL: begin
        regWrite  = 1'b1;
        immSrc    = IMM_J;
        resultSrc = RES_PC4;
        jump      = 1'b1;
      end
      default: ;
    endcase
  end

  // Only R-type with funct7[5] subtracts; addi never does
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000:
            if (opcode[5] && InstrD[30])
              aluControl = ALU_SUB;
          3'b010: aluControl = ALU_SLT;
          3'b110: aluControl = ALU_OR;
          3'b111: aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

  always_comb begin
    immExt = '0;
    case (immSrc)
      IMM_I: immExt = {{20{InstrD[31]}},
                       InstrD[31:20]};
      IMM_S: immExt = {{20{InstrD[31]}},
                       InstrD[31:25], InstrD[11:7]};
      IMM_B: immExt = {{20{InstrD[31]}}, InstrD[7],
                       InstrD[30:25], InstrD[11:8],
                       1'b0};
      IMM_J: immExt = {{12{InstrD[31]}},
                       InstrD[19:12], InstrD[20],
                       InstrD[30:21], 1'b0};
      default: immExt = '0;
    endcase
  end

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .a1  (Rs1D),
    .a2  (Rs2D),
    .we3 (RegWriteW),
    .a3  (RdW),
    .wd3 (ResultW),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  always_comb begin
    nextE            = '0;
    nextE.regWrite   = regWrite;
    nextE.resultSrc  = resultSrc;
    nextE.memWrite   = memWrite;
    nextE.jump       = jump;
    nextE.branch     = branch;
    nextE.aluControl = aluControl;
    nextE.aluSrc     = aluSrc;
    nextE.rd1        = rd1;
    nextE.rd2        = rd2;
    nextE.immExt     = immExt;
    nextE.rd         = InstrD[11:7];
    nextE.rs1        = Rs1D;
    nextE.rs2        = Rs2D;
    nextE.pc         = PCD;
    nextE.pcPlus4    = PCPlus4D;
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE)
      regE <= '0;
    else
      regE <= nextE;
  end

  assign RegWriteE   = regE.regWrite;
  assign ResultSrcE  = regE.resultSrc;
  assign MemWriteE   = regE.memWrite;
  assign JumpE       = regE.jump;
  assign BranchE     = regE.branch;
  assign ALUControlE = regE.aluControl;
  assign ALUSrcE     = regE.aluSrc;
  assign RD1E        = regE.rd1;
  assign RD2E        = regE.rd2;
  assign ImmExtE     = regE.immExt;
  assign RdE         = regE.rd;
  assign Rs1E        = regE.rs1;
  assign Rs2E        = regE.rs2;
  assign PCE         = regE.pc;
  assign PCPlus4E    = regE.pcPlus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed program from the
// bring-up plan, then random traffic against a reference model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE, JumpE, BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [4:0]  RdE, Rs1E, Rs2E;
  logic [31:0] PCE, PCPlus4E;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW),
    .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE),
    .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E)
  );

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] mregs [32];

  logic [31:0] eRw, eRs, eMw, eJ, eB, eCtl, eSrc;
  logic [31:0] eRd1, eRd2, eImm, eRd, eRs1, eRs2;
  logic [31:0] ePc, ePc4;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] readModel(int idx);
    if (idx == 0) return 0;
    if (RegWriteW && RdW == idx[4:0]) return ResultW;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] fnCtl(int f3, bit isR,
                                        bit f7b5);
    case (f3)
      0: return (isR && f7b5) ? 1 : 0;
      2: return 5;
      6: return 3;
      7: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic predict();
    int i31, imm;
    logic [31:0] ins;
    ins = InstrD;
    i31 = int'(ins[31]);
    eRw = 0; eRs = 0; eMw = 0; eJ = 0; eB = 0;
    eCtl = 0; eSrc = 0;
    imm = -2048 * i31 + int'(ins[30:20]);
    case (ins[6:0])
      7'h03: begin eRw = 1; eRs = 1; eSrc = 1; end
      7'h23: begin
        eMw = 1; eSrc = 1;
        imm = -2048 * i31 + 32 * int'(ins[30:25])
              + int'(ins[11:7]);
      end
      7'h33: begin
        eRw = 1;
        eCtl = fnCtl(int'(ins[14:12]), 1, ins[30]);
      end
      7'h63: begin
        eB = 1; eCtl = 1;
        imm = -4096 * i31 + 2048 * int'(ins[7])
              + 32 * int'(ins[30:25]) + 2 * int'(ins[11:8]);
      end
      7'h13: begin
        eRw = 1; eSrc = 1;
        eCtl = fnCtl(int'(ins[14:12]), 0, ins[30]);
      end
      7'h6f: begin
        eRw = 1; eRs = 2; eJ = 1;
        imm = -(1 << 20) * i31 + 4096 * int'(ins[19:12])
              + 2048 * int'(ins[20]) + 2 * int'(ins[30:21]);
      end
      default: ;
    endcase
    eImm = 32'(imm);
    eRd1 = readModel(int'(ins[19:15]));
    eRd2 = readModel(int'(ins[24:20]));
    eRd  = 32'(ins[11:7]);
    eRs1 = 32'(ins[19:15]);
    eRs2 = 32'(ins[24:20]);
    ePc  = PCD;
    ePc4 = PCPlus4D;
    if (rst || FlushE) begin
      eRw = 0; eRs = 0; eMw = 0; eJ = 0; eB = 0;
      eCtl = 0; eSrc = 0; eImm = 0; eRd1 = 0; eRd2 = 0;
      eRd = 0; eRs1 = 0; eRs2 = 0; ePc = 0; ePc4 = 0;
    end
  endtask

  task automatic cycle();
    #1;
    check("Rs1D", 32'(Rs1D), 32'(InstrD[19:15]));
    check("Rs2D", 32'(Rs2D), 32'(InstrD[24:20]));
    predict();
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 0;
    end else if (RegWriteW && RdW != 0) begin
      mregs[RdW] = ResultW;
    end
    check("RegWriteE", 32'(RegWriteE), eRw);
    check("ResultSrcE", 32'(ResultSrcE), eRs);
    check("MemWriteE", 32'(MemWriteE), eMw);
    check("JumpE", 32'(JumpE), eJ);
    check("BranchE", 32'(BranchE), eB);
    check("ALUControlE", 32'(ALUControlE), eCtl);
    check("ALUSrcE", 32'(ALUSrcE), eSrc);
    check("RD1E", RD1E, eRd1);
    check("RD2E", RD2E, eRd2);
    check("ImmExtE", ImmExtE, eImm);
    check("RdE", 32'(RdE), eRd);
    check("Rs1E", 32'(Rs1E), eRs1);
    check("Rs2E", 32'(Rs2E), eRs2);
    check("PCE", PCE, ePc);
    check("PCPlus4E", PCPlus4E, ePc4);
  endtask

  task automatic setInstr(logic [31:0] ins, logic [31:0] pc);
    InstrD = ins;
    PCD = pc;
    PCPlus4D = pc + 4;
  endtask

  initial begin
    logic [6:0] ops [7];
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h63; ops[4] = 7'h13; ops[5] = 7'h6f;
    ops[6] = 7'h00;
    for (int i = 0; i < 32; i++) mregs[i] = 32'hx;
    rst = 1; FlushE = 0; RegWriteW = 0; RdW = 0;
    ResultW = 0;
    setInstr(32'h0, 32'h0);
    cycle();
    rst = 0;

    setInstr(32'h00A00293, 32'h0);
    cycle();
    check("addi.RegWriteE", 32'(RegWriteE), 1);
    check("addi.ImmExtE", ImmExtE, 32'h0000000A);
    check("addi.RdE", 32'(RdE), 5);

    RegWriteW = 1; RdW = 5; ResultW = 32'h0000000A;
    setInstr(32'h00528333, 32'h4);
    cycle();
    check("bypass.RD1E", RD1E, 32'h0000000A);
    check("bypass.RD2E", RD2E, 32'h0000000A);

    RegWriteW = 0;
    setInstr(32'h00502423, 32'h8);
    cycle();
    check("sw.MemWriteE", 32'(MemWriteE), 1);
    check("sw.ImmExtE", ImmExtE, 32'h00000008);
    check("sw.RD2E", RD2E, 32'h0000000A);

    setInstr(32'hFE000EE3, 32'hC);
    cycle();
    check("beq.ALUControlE", 32'(ALUControlE), 1);
    check("beq.ImmExtE", ImmExtE, 32'hFFFFFFFC);

    FlushE = 1;
    setInstr(32'h00A00293, 32'h10);
    cycle();
    check("flush.RegWriteE", 32'(RegWriteE), 0);
    FlushE = 0;

    RegWriteW = 1; RdW = 0; ResultW = 32'hDEADBEEF;
    setInstr(32'h00000013, 32'h14);
    cycle();
    RegWriteW = 0;
    cycle();
    check("x0.RD1E", RD1E, 0);

    rst = 1; RegWriteW = 1; RdW = 5; ResultW = 32'h55;
    setInstr(32'h00528333, 32'h18);
    cycle();
    rst = 0; RegWriteW = 0;
    cycle();
    check("postrst.RD1E", RD1E, 0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0)
        ins[6:0] = ops[$urandom_range(0, 6)];
      setInstr(ins, $urandom & 32'hFFFFFFFC);
      RegWriteW = 1'($urandom_range(0, 1));
      RdW = 5'($urandom_range(0, 31));
      ResultW = $urandom;
      FlushE = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
Second pipeline stage of the RV32I core and the consumer of the fetch stage outputs (InstrD, PCD, PCPlus4D).
- Decodes the instruction and generates control signals.
- Reads the register file, which also receives the writeback port.
- Sign-extends the immediate.
- Registers everything into the D/E pipeline register that feeds the execute stage.
- Supports a hazard-driven flush (bubble insertion) of the execute register.

Parameters:
DATA_WIDTH, 32, datapath/register width
REG_ADDR_W, 5, register index width (2**REG_ADDR_W registers, x0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
InstrD  in  32  instruction from fetch
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  32  writeback data
FlushE  in  1  clear D/E register next edge (bubble)
Rs1D  out  5  InstrD[19:15], combinational, to hazard unit
Rs2D  out  5  InstrD[24:20], combinational, to hazard unit
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  out  1  store enable
JumpE  out  1  jal
BranchE  out  1  beq
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  out  1  1 = immediate operand
RD1E  out  32  rs1 data
RD2E  out  32  rs2 data
ImmExtE  out  32  sign-extended immediate
RdE  out  5  destination
Rs1E  out  5  registered Rs1D
Rs2E  out  5  registered Rs2D
PCE  out  32  registered PCD
PCPlus4E  out  32  registered PCPlus4D

Behaviour:
- Reset: rst=1 at rising edge clears every E output to 0 and clears all register-file entries to 0.
- Priority is rst > FlushE > normal load.
- Latency: one cycle. Values decoded from InstrD during cycle N appear on the E outputs after edge N+1. There is no stall input; the E register loads every cycle.
- FlushE=1 (rst=0): all E outputs load 0 at the next edge. The result is a bubble: no RegWrite, no MemWrite, no Branch, no Jump.
- Register file write: on the rising edge when RegWriteW=1 and RdW!=0, ResultW is written into entry RdW. Writes with RdW=0 are ignored.
- Register file read: x0 always reads 0.
- Write-through bypass: if RegWriteW=1, RdW!=0 and RdW equals the read index, the read returns ResultW in the same cycle. This is equivalent to write-first, and is required because there is no W->D forwarding elsewhere.
- Main decoder (opcode = InstrD[6:0]); fields listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump:
  - 0000011 lw: 1, 00, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, 01, 1, 1, xx->00, 0, 00, 0
  - 0110011 R-type: 1, xx, 0, 0, 00, 0, 10, 0
  - 1100011 beq: 0, 10, 0, 0, 00, 1, 01, 0
  - 0010011 I-ALU: 1, 00, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, 11, x, 0, 10, 0, xx, 1
  - Any other opcode: all controls 0, so the E register receives a bubble. Don't-cares are driven 0.
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000: sub if {op[5], funct7[5]}==11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Other funct3: add.
- Immediate extend (all sign-extended from InstrD[31]):
  - ImmSrc 00, I: InstrD[31:20].
  - ImmSrc 01, S: {InstrD[31:25], InstrD[11:7]}.
  - ImmSrc 10, B: {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
  - ImmSrc 11, J: {InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 0}.
- RdE loads InstrD[11:7] regardless of instruction type. Rs1E and Rs2E load the raw fields.
- A simultaneous writeback and flush still writes the register file; flush affects only the E register.
- rst asserted mid-stream clears the register file and the E register in the same edge, and takes precedence over a concurrent RegWriteW.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_B, OP_I, OP_JAL
  - ALU control encodings
  - ResultSrc and ImmSrc encodings
- The fetch, execute and hazard blocks reuse the same package.
- One sub-module, register_file, contains the 32x32 array, sync reset, the x0 rule and the write-through bypass.
- The main decoder, ALU decoder and immediate extend are internal combinational logic of decode_cycle.

Test Plan:
- Reset then InstrD=0x00A00293 (addi x5,x0,10), PCD=0x0 -> after the next edge: RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=0x0000000A, RdE=5, RD1E=0.
- Same cycle: RegWriteW=1, RdW=5, ResultW=0x0000000A, and InstrD=0x00528333 (add x6,x5,x5) -> next edge: RD1E=RD2E=0x0000000A (bypass), ALUSrcE=0, RdE=6.
- InstrD=0x00502423 (sw x5,8(x0)) -> MemWriteE=1, RegWriteE=0, ImmExtE=0x00000008, RD2E=0x0000000A.
- InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC. Then FlushE=1 with a valid addi -> all E outputs 0 the next cycle.
- Write RdW=0, ResultW=0xDEADBEEF, then read x0 -> RD1E=0. Assert rst after x5 was written -> all E outputs 0, and a subsequent read of x5 returns 0.
